// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix-processing-unit sequencer.
// Holds the state encoding, opcode values, matrix word width and size codes.
package mpu_pkg;

    // Flattened 5x5 matrix of 8-bit elements.
    localparam int MAT_W = 200;

    // Operation size codes presented to the matrix unit.
    localparam logic [7:0] SIZE_2X2 = 8'd2;
    localparam logic [7:0] SIZE_3X3 = 8'd3;

    // Opcodes understood by the downstream matrix unit; the sequencer only forwards them.
    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_MUL       = 3'd2;
    localparam logic [2:0] OP_TRANSPOSE = 3'd3;
    localparam logic [2:0] OP_SCALE     = 3'd4;
    localparam logic [2:0] OP_HADAMARD  = 3'd5;
    localparam logic [2:0] OP_COPY      = 3'd6;
    localparam logic [2:0] OP_NOP       = 3'd7;

    // Numeric encoding is also what the LEDs show on state_dbg.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_A  = 4'd1,
        S_LD_A  = 4'd2,
        S_RD_B  = 4'd3,
        S_LD_B  = 4'd4,
        S_EXEC  = 4'd5,
        S_WAIT  = 4'd6,
        S_WRITE = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    // Maps the size select input to the size code (1 -> 2x2, 0 -> 3x3).
    function automatic logic [7:0] size_of(input logic sel);
        return sel ? SIZE_2X2 : SIZE_3X3;
    endfunction

endpackage

// File: rtl/mpu_lat_counter.sv
// Loadable down-counter used both for the memory read-latency wait and the
// op_done watchdog. 'expired' is high whenever the count sits at zero.
module mpu_lat_counter #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         expired
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while running and stop at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mpu_sequencer.sv
// Sequencer for the matrix processing unit: fetches operand A from base and
// operand B from base+1, launches the matrix unit, and writes its result to
// base+2 (all addresses wrap). Optional op_done watchdog is enabled by
// defining MPU_SEQ_TIMEOUT_EN; without it WAIT waits forever and timeout is 0.
module mpu_sequencer
    import mpu_pkg::*;
#(
    parameter int DATA_W      = MAT_W,
    parameter int ADDR_W      = 3,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic              size_sel,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              op_start,
    output logic [2:0]        op_code,
    output logic [7:0]        op_size,
    output logic [DATA_W-1:0] matrix_a,
    output logic [DATA_W-1:0] matrix_b,
    input  logic [DATA_W-1:0] op_result,
    input  logic              op_done,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [3:0]        state_dbg
);

    // RD_LAT is limited to 1..3, so a 2-bit latency counter suffices.
    localparam int RD_W = 2;
    localparam logic [RD_W-1:0] RD_LOAD = RD_W'(RD_LAT - 1);

    state_t            state;
    state_t            next_state;
    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [2:0]        opcode_reg;
    logic              size_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              start_accept;
    logic              rd_expired;
    logic              wd_fire;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int    = rst_sync[1];
    assign start_accept = (state == S_IDLE) && start;

    // Read-latency wait, reloaded on entry to RD_A and RD_B.
    mpu_lat_counter #(.W(RD_W)) u_rd_lat (
        .clock    (clock),
        .reset_n  (rst_n_int),
        .load     (start_accept || (state == S_LD_A)),
        .load_val (RD_LOAD),
        .run      ((state == S_RD_A) || (state == S_RD_B)),
        .expired  (rd_expired)
    );

`ifdef MPU_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic wd_expired;

    // Loaded with TIMEOUT_CYC-2 so WAIT lasts TIMEOUT_CYC-1 cycles; with FIN
    // and the registered done, done lands TIMEOUT_CYC cycles after WAIT entry.
    mpu_lat_counter #(.W(WD_W)) u_watchdog (
        .clock    (clock),
        .reset_n  (rst_n_int),
        .load     (state == S_EXEC),
        .load_val (WD_W'(TIMEOUT_CYC - 2)),
        .run      (state == S_WAIT),
        .expired  (wd_expired)
    );

    assign wd_fire = (state == S_WAIT) && !op_done && wd_expired;

    // Sticky timeout flag, cleared only by the next accepted start or reset.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            timeout <= 1'b0;
        end else if (start_accept) begin
            timeout <= 1'b0;
        end else if (wd_fire) begin
            timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture; inputs are ignored for the rest of the run.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            opcode_reg <= '0;
            size_reg   <= 1'b0;
            base_reg   <= '0;
        end else if (start_accept) begin
            opcode_reg <= opcode;
            size_reg   <= size_sel;
            base_reg   <= base_addr;
        end
    end

    // Operand and result registers; operands persist until reloaded.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            matrix_a  <= '0;
            matrix_b  <= '0;
            mem_wdata <= '0;
        end else begin
            if (state == S_LD_A) begin
                matrix_a <= mem_rdata;
            end
            if (state == S_LD_B) begin
                matrix_b <= mem_rdata;
            end
            if ((state == S_WAIT) && op_done) begin
                mem_wdata <= op_result;
            end
        end
    end

    // done is registered from FIN, so it pulses the cycle after FIN.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_FIN);
        end
    end

    // Next-state logic; op_done matters only in WAIT.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RD_A;
            S_RD_A:  if (rd_expired) next_state = S_LD_A;
            S_LD_A:  next_state = S_RD_B;
            S_RD_B:  if (rd_expired) next_state = S_LD_B;
            S_LD_B:  next_state = S_EXEC;
            S_EXEC:  next_state = S_WAIT;
            S_WAIT: begin
                if (op_done) begin
                    next_state = S_WRITE;
                end else if (wd_fire) begin
                    next_state = S_FIN;
                end
            end
            S_WRITE: next_state = S_FIN;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; address offsets wrap at the address width.
    always_comb begin
        mem_addr = base_reg;
        mem_wren = 1'b0;
        op_start = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_RD_B, S_LD_B: mem_addr = base_reg + ADDR_W'(1);
            S_EXEC:         op_start = 1'b1;
            S_WRITE: begin
                mem_addr = base_reg + ADDR_W'(2);
                mem_wren = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_code   = opcode_reg;
    assign op_size   = size_of(size_reg);
    assign state_dbg = state;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed self-checking bench for mpu_sequencer with a 1-cycle-latency
// synchronous memory model. Timeout checks depend on MPU_SEQ_TIMEOUT_EN.
module tb_mpu_sequencer;
    import mpu_pkg::*;

    localparam int DATA_W      = 200;
    localparam int ADDR_W      = 3;
    localparam int RD_LAT      = 1;
    localparam int TIMEOUT_CYC = 16;

    localparam logic [DATA_W-1:0] A0 = {25{8'hA0}};
    localparam logic [DATA_W-1:0] B0 = {25{8'hB0}};
    localparam logic [DATA_W-1:0] A7 = {25{8'hA7}};
    localparam logic [DATA_W-1:0] R0 = {25{8'hC0}};
    localparam logic [DATA_W-1:0] R1 = {25{8'hC1}};
    localparam logic [DATA_W-1:0] R2 = {25{8'hC2}};
    localparam logic [DATA_W-1:0] R3 = {25{8'hC3}};
    localparam logic [DATA_W-1:0] R4 = {25{8'hC4}};

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [2:0]        opcode;
    logic              size_sel;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              op_start;
    logic [2:0]        op_code;
    logic [7:0]        op_size;
    logic [DATA_W-1:0] matrix_a;
    logic [DATA_W-1:0] matrix_b;
    logic [DATA_W-1:0] op_result;
    logic              op_done;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [3:0]        state_dbg;

    logic [DATA_W-1:0] mem [8];
    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int wren_pulses = 0;
    int d0;
    int w0;

    mpu_sequencer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RD_LAT      (RD_LAT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .size_sel  (size_sel),
        .base_addr (base_addr),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .op_start  (op_start),
        .op_code   (op_code),
        .op_size   (op_size),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .op_result (op_result),
        .op_done   (op_done),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory: one cycle read latency, write on mem_wren.
    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Pulse counters sampled on the falling edge.
    always @(negedge clock) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
        if (mem_wren === 1'b1) wren_pulses <= wren_pulses + 1;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Advance to just after the next falling edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_output(input string tag, input logic [DATA_W-1:0] observed,
                                input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start request; inputs are scrambled afterwards to prove capture.
    task automatic apply_stimulus(input logic [2:0] op, input logic sz,
                                  input logic [ADDR_W-1:0] base);
        opcode    = op;
        size_sel  = sz;
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        opcode    = ~op;
        size_sel  = ~sz;
        base_addr = ~base;
    endtask

    task automatic wait_state(input logic [3:0] target, input int budget, input string tag);
        int n = 0;
        while ((state_dbg !== target) && (n < budget)) begin
            tick();
            n++;
        end
        check_output(tag, state_dbg, target);
    endtask

    task automatic pulse_op_done(input logic [DATA_W-1:0] res);
        op_result = res;
        op_done   = 1'b1;
        tick();
        op_done   = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        opcode    = '0;
        size_sel  = 1'b0;
        base_addr = '0;
        op_done   = 1'b0;
        op_result = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = A0;
        mem[1] = B0;
        mem[7] = A7;
        ticks(2);

        // Reset state
        check_output("rst_state", state_dbg, S_IDLE);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_wren", mem_wren, 1'b0);
        check_output("rst_op_start", op_start, 1'b0);
        check_output("rst_timeout", timeout, 1'b0);
        check_output("rst_matrix_a", matrix_a, '0);
        check_output("rst_matrix_b", matrix_b, '0);
        check_output("rst_wdata", mem_wdata, '0);
        check_output("rst_addr", mem_addr, '0);
        reset_n = 1'b1;
        ticks(3);

        // Base run: done at cycle 10, busy cycles 1..9
        apply_stimulus(OP_MUL, 1'b0, 3'd0);
        check_output("base_c1_state", state_dbg, S_RD_A);
        check_output("base_c1_busy", busy, 1'b1);
        check_output("base_c1_addr", mem_addr, 3'd0);
        tick();
        check_output("base_c2_state", state_dbg, S_LD_A);
        tick();
        check_output("base_c3_state", state_dbg, S_RD_B);
        check_output("base_c3_addr", mem_addr, 3'd1);
        check_output("base_c3_matrix_a", matrix_a, A0);
        tick();
        check_output("base_c4_state", state_dbg, S_LD_B);
        tick();
        check_output("base_c5_state", state_dbg, S_EXEC);
        check_output("base_c5_op_start", op_start, 1'b1);
        check_output("base_c5_matrix_b", matrix_b, B0);
        check_output("base_c5_op_code", op_code, OP_MUL);
        check_output("base_c5_op_size", op_size, 8'd3);
        tick();
        check_output("base_c6_state", state_dbg, S_WAIT);
        check_output("base_c6_op_start", op_start, 1'b0);
        tick();
        pulse_op_done(R0);
        check_output("base_c8_state", state_dbg, S_WRITE);
        check_output("base_c8_wren", mem_wren, 1'b1);
        check_output("base_c8_addr", mem_addr, 3'd2);
        check_output("base_c8_wdata", mem_wdata, R0);
        tick();
        check_output("base_c9_state", state_dbg, S_FIN);
        check_output("base_c9_wren", mem_wren, 1'b0);
        check_output("base_c9_busy", busy, 1'b1);
        check_output("base_c9_done", done, 1'b0);
        tick();
        check_output("base_c10_state", state_dbg, S_IDLE);
        check_output("base_c10_busy", busy, 1'b0);
        check_output("base_c10_done", done, 1'b1);
        tick();
        check_output("base_c11_done", done, 1'b0);
        check_output("base_mem2", mem[2], R0);

        // Address wrap: base 7 reads 7 then 0, writes 1
        apply_stimulus(OP_ADD, 1'b0, 3'd7);
        check_output("wrap_addr_a", mem_addr, 3'd7);
        ticks(2);
        check_output("wrap_addr_b", mem_addr, 3'd0);
        wait_state(S_WAIT, 20, "wrap_reach_wait");
        pulse_op_done(R1);
        check_output("wrap_wren", mem_wren, 1'b1);
        check_output("wrap_addr_w", mem_addr, 3'd1);
        wait_state(S_IDLE, 10, "wrap_reach_idle");
        check_output("wrap_matrix_a", matrix_a, A7);
        check_output("wrap_matrix_b", matrix_b, A0);
        check_output("wrap_mem1", mem[1], R1);

        // Sizing: 2x2, opcode 5 held from EXEC through FIN
        apply_stimulus(3'b101, 1'b1, 3'd0);
        wait_state(S_EXEC, 20, "size_reach_exec");
        check_output("size_exec_op_size", op_size, 8'd2);
        check_output("size_exec_op_code", op_code, 3'd5);
        wait_state(S_WAIT, 5, "size_reach_wait");
        pulse_op_done(R2);
        wait_state(S_FIN, 5, "size_reach_fin");
        check_output("size_fin_op_size", op_size, 8'd2);
        check_output("size_fin_op_code", op_code, 3'd5);
        wait_state(S_IDLE, 5, "size_reach_idle");
        check_output("size_mem2", mem[2], R2);

        // Start during WAIT is ignored
        d0 = done_pulses;
        w0 = wren_pulses;
        apply_stimulus(OP_SUB, 1'b0, 3'd0);
        wait_state(S_WAIT, 20, "busy_reach_wait");
        opcode    = OP_COPY;
        base_addr = 3'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check_output("busy_still_wait", state_dbg, S_WAIT);
        check_output("busy_op_code_held", op_code, OP_SUB);
        ticks(2);
        pulse_op_done(R3);
        wait_state(S_IDLE, 10, "busy_reach_idle");
        ticks(15);
        check_output("busy_done_count", done_pulses - d0, 1);
        check_output("busy_wren_count", wren_pulses - w0, 1);
        check_output("busy_final_state", state_dbg, S_IDLE);
        check_output("busy_mem2", mem[2], R3);

        // Reset during WAIT aborts the run
        w0 = wren_pulses;
        apply_stimulus(OP_ADD, 1'b0, 3'd0);
        wait_state(S_WAIT, 20, "mrst_reach_wait");
        reset_n = 1'b0;
        #1;
        check_output("mrst_state", state_dbg, S_IDLE);
        check_output("mrst_busy", busy, 1'b0);
        check_output("mrst_matrix_a", matrix_a, '0);
        tick();
        reset_n = 1'b1;
        ticks(3);
        pulse_op_done(R4);
        ticks(2);
        check_output("mrst_idle_after", state_dbg, S_IDLE);
        check_output("mrst_no_wren", wren_pulses - w0, 0);
        check_output("mrst_mem2_kept", mem[2], R3);
        apply_stimulus(OP_ADD, 1'b0, 3'd0);
        wait_state(S_WAIT, 20, "mrst_fresh_wait");
        pulse_op_done(R4);
        wait_state(S_IDLE, 10, "mrst_fresh_idle");
        check_output("mrst_fresh_mem2", mem[2], R4);
        check_output("mrst_fresh_matrix_a", matrix_a, A0);

`ifdef MPU_SEQ_TIMEOUT_EN
        // Watchdog: no op_done, done 16 cycles after WAIT entry
        d0 = done_pulses;
        w0 = wren_pulses;
        apply_stimulus(OP_MUL, 1'b0, 3'd0);
        wait_state(S_WAIT, 20, "to_reach_wait");
        ticks(15);
        check_output("to_fin_state", state_dbg, S_FIN);
        check_output("to_fin_timeout", timeout, 1'b1);
        check_output("to_fin_done", done, 1'b0);
        tick();
        check_output("to_done", done, 1'b1);
        check_output("to_idle", state_dbg, S_IDLE);
        ticks(3);
        check_output("to_sticky", timeout, 1'b1);
        check_output("to_no_wren", wren_pulses - w0, 0);
        check_output("to_done_count", done_pulses - d0, 1);
        apply_stimulus(OP_MUL, 1'b0, 3'd0);
        check_output("to_cleared", timeout, 1'b0);
        wait_state(S_WAIT, 20, "to_next_wait");
        pulse_op_done(R0);
        wait_state(S_IDLE, 10, "to_next_idle");
        check_output("to_next_timeout", timeout, 1'b0);
`else
        // Without the watchdog WAIT waits indefinitely
        apply_stimulus(OP_MUL, 1'b0, 3'd0);
        wait_state(S_WAIT, 20, "nto_reach_wait");
        ticks(30);
        check_output("nto_still_wait", state_dbg, S_WAIT);
        check_output("nto_timeout", timeout, 1'b0);
        pulse_op_done(R0);
        wait_state(S_IDLE, 10, "nto_reach_idle");
        check_output("nto_mem2", mem[2], R0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
